// File: rtl/tdl_pkg.sv
// Shared definitions for the tagged delay line: delay-field width, FSM encoding, lane helper.
`ifndef TDL_LANE
`define TDL_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package tdl_pkg;

    function automatic int tdl_dly_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } tdl_state_e;

endpackage

// File: rtl/tdl_cfg_ctrl.sv
// Delay-change control: applies legal requests directly when idle, otherwise drains first.
module tdl_cfg_ctrl
    import tdl_pkg::*;
#(
    parameter int MAX_DELAY = 22,
    parameter int DLY_W     = tdl_dly_w(MAX_DELAY)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             cfg_valid_i,
    input  logic [DLY_W-1:0] cfg_delay_i,
    input  logic             any_valid_i,
    output logic [DLY_W-1:0] cur_delay_o,
    output logic             cfg_err_o,
    output logic             din_ready_o,
    output tdl_state_e       state_o
);
    tdl_state_e       state_q;
    logic [DLY_W-1:0] cur_delay_q;
    logic [DLY_W-1:0] pend_q;
    logic             cfg_err_q;
    logic             cfg_legal;

    assign cfg_legal = (cfg_delay_i != '0) && (cfg_delay_i <= DLY_W'(MAX_DELAY));

    // A flush empties the pipeline, so a pending change can land at once and
    // a simultaneous request in RUN is treated as if the line were idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            cur_delay_q <= DLY_W'(MAX_DELAY);
            pend_q      <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (flush_i && state_q == ST_DRAIN) begin
                cur_delay_q <= pend_q;
                state_q     <= ST_RUN;
                if (en_i && cfg_valid_i) cfg_err_q <= 1'b1;
            end else if (en_i) begin
                if (state_q == ST_RUN) begin
                    if (cfg_valid_i) begin
                        if (!cfg_legal) begin
                            cfg_err_q <= 1'b1;
                        end else if (any_valid_i && !flush_i) begin
                            pend_q  <= cfg_delay_i;
                            state_q <= ST_DRAIN;
                        end else begin
                            cur_delay_q <= cfg_delay_i;
                        end
                    end
                end else begin
                    if (cfg_valid_i) cfg_err_q <= 1'b1;
                    if (!any_valid_i) begin
                        cur_delay_q <= pend_q;
                        state_q     <= ST_RUN;
                    end
                end
            end
        end
    end

    assign cur_delay_o = cur_delay_q;
    assign cfg_err_o   = cfg_err_q;
    assign state_o     = state_q;
    assign din_ready_o = (state_q == ST_RUN) & en_i & ~flush_i;

endmodule

// File: rtl/tagged_delay_line.sv
// Runtime-programmable, valid-tagged multi-lane delay line (1..MAX_DELAY cycles).
// Define TDL_ZERO_FILL_EN to force dout to zero whenever dout_valid is low.
module tagged_delay_line
    import tdl_pkg::*;
#(
    parameter int  DATA_LENGTH = 8,
    parameter int  CHANNELS    = 4,
    parameter int  MAX_DELAY   = 22,
    localparam int DLY_W       = tdl_dly_w(MAX_DELAY),
    localparam int W           = CHANNELS * DATA_LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             cfg_valid,
    input  logic [DLY_W-1:0] cfg_delay,
    output logic             cfg_err,
    input  logic             flush,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    output logic [DLY_W-1:0] cur_delay,
    output logic             busy
);
    logic [W-1:0]       data_q [1:MAX_DELAY];
    logic [MAX_DELAY:1] vld_q;
    logic [MAX_DELAY:1] tap_mask;
    logic [W-1:0]       tap_data;
    logic               tap_vld;
    logic               any_valid;
    logic               accept;
    tdl_state_e         ctrl_state;

    tdl_cfg_ctrl #(
        .MAX_DELAY(MAX_DELAY),
        .DLY_W    (DLY_W)
    ) u_ctrl (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .flush_i    (flush),
        .cfg_valid_i(cfg_valid),
        .cfg_delay_i(cfg_delay),
        .any_valid_i(any_valid),
        .cur_delay_o(cur_delay),
        .cfg_err_o  (cfg_err),
        .din_ready_o(din_ready),
        .state_o    (ctrl_state)
    );

    assign accept = din_valid & din_ready;

    // tap_mask marks the stages inside the active window 1..cur_delay.
    always_comb begin
        tap_mask = '0;
        tap_data = '0;
        tap_vld  = 1'b0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            tap_mask[k] = (DLY_W'(k) <= cur_delay);
            if (DLY_W'(k) == cur_delay) begin
                tap_data = data_q[k];
                tap_vld  = vld_q[k];
            end
        end
    end

    assign any_valid = |(vld_q & tap_mask);
    assign busy      = any_valid | (ctrl_state == ST_DRAIN);

    // Data always shifts on enable; only the valid tags are windowed and flushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 1; k <= MAX_DELAY; k++) data_q[k] <= '0;
        end else begin
            if (en) begin
                data_q[1] <= din;
                for (int k = 2; k <= MAX_DELAY; k++) data_q[k] <= data_q[k-1];
            end
            if (flush) begin
                vld_q <= '0;
            end else if (en) begin
                vld_q <= {vld_q[MAX_DELAY-1:1], accept} & tap_mask;
            end
        end
    end

    assign dout_valid = tap_vld;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
`ifdef TDL_ZERO_FILL_EN
        assign `TDL_LANE(dout, g, DATA_LENGTH) = tap_vld ? `TDL_LANE(tap_data, g, DATA_LENGTH) : '0;
`else
        assign `TDL_LANE(dout, g, DATA_LENGTH) = `TDL_LANE(tap_data, g, DATA_LENGTH);
`endif
    end

endmodule

// File: tb/tb_tagged_delay_line.sv
// Bench for tagged_delay_line: directed scenarios plus random traffic against a sample-age model.
// Build with TDL_ZERO_FILL_EN defined to exercise the zero-fill output variant.
module tb_tagged_delay_line;
    import tdl_pkg::*;

    localparam int DL   = 8;
    localparam int CH   = 4;
    localparam int MAXD = 22;
    localparam int DW   = $clog2(MAXD + 1);
    localparam int W    = DL * CH;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          en        = 1'b0;
    logic [W-1:0]  din       = '0;
    logic          din_valid = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_delay = '0;
    logic          flush     = 1'b0;
    logic          din_ready;
    logic          cfg_err;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [DW-1:0] cur_delay;
    logic          busy;

    tagged_delay_line #(
        .DATA_LENGTH(DL),
        .CHANNELS   (CH),
        .MAX_DELAY  (MAXD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .cfg_valid (cfg_valid),
        .cfg_delay (cfg_delay),
        .cfg_err   (cfg_err),
        .flush     (flush),
        .dout      (dout),
        .dout_valid(dout_valid),
        .cur_delay (cur_delay),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted sample carries its age in enabled edges.
    // A sample is visible when its age equals the delay in force and is lost
    // once it ages past that delay. hist[i] is din at the (i+1)-th most recent
    // enabled edge, which is what an untagged tap would show.
    logic [W-1:0] exp_q[$];
    int           age_q[$];
    logic [W-1:0] hist [MAXD];
    int           m_cur   = MAXD;
    int           m_pend  = 0;
    bit           m_drain = 1'b0;
    bit           m_err   = 1'b0;
    bit           live    = 1'b0;
    int           edge_n  = 0;
    int           last_acc = 0;

    function automatic bit m_any();
        foreach (age_q[i]) if (age_q[i] >= 1 && age_q[i] <= m_cur) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_tap();
        foreach (age_q[i]) if (age_q[i] == m_cur) return i;
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        age_q.delete();
        for (int i = 0; i < MAXD; i++) hist[i] = '0;
        m_cur   = MAXD;
        m_pend  = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        bit acc, legal, any, nerr, ndrain;
        int ncur, npend;
        edge_n++;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        acc    = din_valid && !m_drain && en && !flush;
        legal  = (cfg_delay >= 1) && (cfg_delay <= MAXD);
        any    = m_any();
        ncur   = m_cur;
        npend  = m_pend;
        ndrain = m_drain;
        nerr   = 1'b0;
        if (flush && m_drain) begin
            ncur   = m_pend;
            ndrain = 1'b0;
            nerr   = en && cfg_valid;
        end else if (en && cfg_valid && (!legal || m_drain)) begin
            nerr = 1'b1;
        end else if (en && cfg_valid) begin
            if (any && !flush) begin
                npend  = cfg_delay;
                ndrain = 1'b1;
            end else begin
                ncur = cfg_delay;
            end
        end
        if (en && m_drain && !flush && !any) begin
            ncur   = m_pend;
            ndrain = 1'b0;
        end
        if (flush) begin
            exp_q.delete();
            age_q.delete();
        end else if (en) begin
            for (int i = age_q.size() - 1; i >= 0; i--) begin
                age_q[i]++;
                if (age_q[i] > m_cur) begin
                    age_q.delete(i);
                    exp_q.delete(i);
                end
            end
            if (acc) begin
                exp_q.push_back(din);
                age_q.push_back(1);
                last_acc = edge_n;
            end
        end
        if (en) begin
            for (int i = MAXD - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = din;
        end
        m_cur   = ncur;
        m_pend  = npend;
        m_drain = ndrain;
        m_err   = nerr;
    endtask

    task automatic compare_outputs();
        int           idx;
        logic [W-1:0] exp_dout;
        idx = m_tap();
        if (idx >= 0) begin
            exp_dout = exp_q[idx];
        end else begin
`ifdef TDL_ZERO_FILL_EN
            exp_dout = '0;
`else
            exp_dout = hist[m_cur-1];
`endif
        end
        check("dout_valid", dout_valid, idx >= 0);
        check("dout", dout, exp_dout);
        check("cur_delay", cur_delay, m_cur);
        check("busy", busy, m_any() || m_drain);
        check("cfg_err", cfg_err, m_err);
        check("din_ready", din_ready, !m_drain && en && !flush);
    endtask

    // Inputs are set at the falling edge; outputs are compared just after.
    task automatic cycle();
        #1;
        if (live) compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send_cfg(input int d);
        cfg_valid = 1'b1;
        cfg_delay = DW'(d);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [W-1:0] v);
        din       = v;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
    endtask

    task automatic wait_dout_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (dout_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    initial begin
        bit seen;
        int acc0, nout;

        // Reset
        rst_n = 1'b0;
        cycle();
        live = 1'b1;
        cycle();
        check("rst_cur_delay", cur_delay, MAXD);
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        cycle();

        // Delay 5, stream 1,2,3
        send_cfg(5);
        check("t1_cur_delay", cur_delay, 5);
        send_sample(W'(1));
        acc0 = last_acc;
        send_sample(W'(2));
        send_sample(W'(3));
        wait_dout_valid(20, seen);
        check("t1_latency", seen ? (edge_n - acc0 + 1) : -1, 5);
        check("t1_d1", dout, 1);
        cycle();
        check("t1_v2", dout_valid, 1);
        check("t1_d2", dout, 2);
        cycle();
        check("t1_v3", dout_valid, 1);
        check("t1_d3", dout, 3);
        cycle();
        check("t1_end", dout_valid, 0);

        // Stall mid-flight
        repeat (3) cycle();
        send_sample(32'hC3C3C35A);
        acc0 = last_acc;
        cycle();
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        wait_dout_valid(20, seen);
        check("t2_latency", seen ? (edge_n - acc0 + 1) : -1, 8);
        check("t2_data", dout, 32'hC3C3C35A);
        cycle();
        check("t2_no_dup", dout_valid, 0);

        // Reconfigure under load
        repeat (3) cycle();
        send_cfg(10);
        for (int i = 0; i < 4; i++) send_sample(W'(32'h31 + i));
        send_cfg(3);
        check("t3_state_drain", dut.u_ctrl.state_o, ST_DRAIN);
        check("t3_ready_low", din_ready, 0);
        check("t3_cur_kept", cur_delay, 10);
        nout = 0;
        for (int i = 0; i < 40; i++) begin
            if (cur_delay == DW'(3)) break;
            if (dout_valid) nout++;
            cycle();
        end
        check("t3_drained", nout, 4);
        check("t3_cur_new", cur_delay, 3);
        check("t3_state_run", dut.u_ctrl.state_o, ST_RUN);
        send_sample(W'(32'h77));
        acc0 = last_acc;
        wait_dout_valid(20, seen);
        check("t3_latency", seen ? (edge_n - acc0 + 1) : -1, 3);
        check("t3_data", dout, 32'h77);
        repeat (2) cycle();

        // Illegal delays
        send_cfg(0);
        check("t4_err0", cfg_err, 1);
        check("t4_cur0", cur_delay, 3);
        cycle();
        check("t4_err0_clr", cfg_err, 0);
        send_cfg(MAXD + 1);
        check("t4_err23", cfg_err, 1);
        check("t4_cur23", cur_delay, 3);
        cycle();
        check("t4_err23_clr", cfg_err, 0);

        // Flush with samples in flight and a simultaneous input
        din = 32'hA5A5A5A5;
        repeat (4) cycle();
        send_cfg(10);
        for (int i = 0; i < 6; i++) send_sample({24'($urandom), 8'(8'h11 + i)});
        flush     = 1'b1;
        din       = 32'hEEEEEEEE;
        din_valid = 1'b1;
        cycle();
        flush     = 1'b0;
        din_valid = 1'b0;
        check("t5_valid", dout_valid, 0);
        check("t5_busy", busy, 0);
`ifdef TDL_ZERO_FILL_EN
        check("t5_zero", dout, 0);
`else
        check("t5_stale", dout != '0, 1);
`endif
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (dout_valid) seen = 1'b1;
            cycle();
        end
        check("t5_dropped", seen, 0);

        // Reset while draining toward delay 2
        for (int i = 0; i < 3; i++) send_sample(W'(32'h51 + i));
        send_cfg(2);
        check("t6_state_drain", dut.u_ctrl.state_o, ST_DRAIN);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("t6_cur", cur_delay, MAXD);
        check("t6_dout", dout, 0);
        check("t6_valid", dout_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_err", cfg_err, 0);
        check("t6_state", dut.u_ctrl.state_o, ST_RUN);
        repeat (30) cycle();
        check("t6_pending_lost", cur_delay, MAXD);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 99) < 85);
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 99) < 60);
            cfg_valid = ($urandom_range(0, 99) < 4);
            cfg_delay = DW'($urandom_range(0, MAXD + 2));
            flush     = ($urandom_range(0, 99) < 2);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
